// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: operation and state encodings,
// step count and small op-decoding helpers.
package div_unit_pkg;

  localparam int DIV_WORD_W = 32;
  localparam int DIV_STEPS  = 32;
  localparam int DIV_CNT_W  = 6;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'd0,
    DIV_OP_DIVU = 2'd1,
    DIV_OP_REM  = 2'd2,
    DIV_OP_REMU = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    DIV_STATE_IDLE = 2'd0,
    DIV_STATE_CALC = 2'd1,
    DIV_STATE_DONE = 2'd2
  } div_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when it is non-negative.
module div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem_in,
  input  logic [W-1:0] divisor,
  input  logic         dividend_msb,
  output logic [W:0]   rem_out,
  output logic         q_bit
);

  logic [W:0] shifted;
  logic [W:0] trial;

  // rem_in < divisor keeps the trial difference inside the W+1 bit signed range
  always_comb begin
    shifted = {rem_in[W-1:0], dividend_msb};
    trial   = shifted - {1'b0, divisor};
    q_bit   = ~trial[W];
    rem_out = q_bit ? trial : shifted;
  end

endmodule

// File: rtl/div_unit.sv
// Iterative DIV/DIVU/REM/REMU unit, one restoring step per clock.
// Optional macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow finish in one cycle.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WORD_W = DIV_WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WORD_W-1:0] arg0,
  input  logic [WORD_W-1:0] arg1,
  input  logic              kill,
  output logic              busy,
  output logic              valid,
  output logic [WORD_W-1:0] val
);

  localparam logic [WORD_W-1:0] ONES    = '1;
  localparam logic [WORD_W-1:0] MIN_NEG = {1'b1, {(WORD_W-1){1'b0}}};

  div_state_e           state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [WORD_W:0]      rem_q, rem_d;
  logic [WORD_W-1:0]    quo_q, quo_d;      // dividend bits shift out, quotient bits shift in
  logic [WORD_W-1:0]    divisor_q, divisor_d;
  logic                 q_neg_q, q_neg_d;
  logic                 r_neg_q, r_neg_d;
  logic                 div_zero_q, div_zero_d;
  logic                 ovf_q, ovf_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic [WORD_W-1:0]    val_q, val_d;

  logic                 in_signed, a0_neg, a1_neg, in_div_zero, in_ovf, accept;
  logic [WORD_W:0]      step_rem;
  logic                 step_q;
  logic [WORD_W-1:0]    quo_fin, rem_fin, q_signed, r_signed, fix_val;
`ifdef DIV_FAST_SPECIAL_EN
  logic [WORD_W-1:0]    special_val;
`endif

  div_step #(.W(WORD_W)) u_step (
    .rem_in       (rem_q),
    .divisor      (divisor_q),
    .dividend_msb (quo_q[WORD_W-1]),
    .rem_out      (step_rem),
    .q_bit        (step_q)
  );

  always_comb begin
    in_signed   = op_is_signed(op);
    a0_neg      = in_signed & arg0[WORD_W-1];
    a1_neg      = in_signed & arg1[WORD_W-1];
    in_div_zero = (arg1 == '0);
    in_ovf      = in_signed & (arg0 == MIN_NEG) & (arg1 == ONES);
    accept      = start & ~kill & (state_q != DIV_STATE_CALC);
`ifdef DIV_FAST_SPECIAL_EN
    if (in_div_zero) special_val = op_is_rem(op) ? arg0 : ONES;
    else             special_val = op_is_rem(op) ? '0 : MIN_NEG;
`endif

    // Result as it will be after the final step; sign fix-up and special cases.
    // A zero divisor leaves |dividend| in the remainder, so REM by zero falls out as arg0.
    quo_fin  = {quo_q[WORD_W-2:0], step_q};
    rem_fin  = step_rem[WORD_W-1:0];
    q_signed = q_neg_q ? -quo_fin : quo_fin;
    r_signed = r_neg_q ? -rem_fin : rem_fin;
    if (div_zero_q)   fix_val = op_is_rem(op_q) ? r_signed : ONES;
    else if (ovf_q)   fix_val = op_is_rem(op_q) ? '0 : MIN_NEG;
    else              fix_val = op_is_rem(op_q) ? r_signed : q_signed;

    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    divisor_d  = divisor_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;
    val_d      = val_q;

    case (state_q)
      DIV_STATE_CALC: begin
        rem_d = step_rem;
        quo_d = quo_fin;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DIV_CNT_W'(WORD_W - 1)) begin
          state_d = DIV_STATE_DONE;
          val_d   = fix_val;
        end
      end
      DIV_STATE_DONE: state_d = DIV_STATE_IDLE;
      default:        state_d = DIV_STATE_IDLE;
    endcase

    if (accept) begin
      state_d    = DIV_STATE_CALC;
      op_d       = op;
      cnt_d      = '0;
      rem_d      = '0;
      quo_d      = a0_neg ? -arg0 : arg0;
      divisor_d  = a1_neg ? -arg1 : arg1;
      q_neg_d    = a0_neg ^ a1_neg;
      r_neg_d    = a0_neg;
      div_zero_d = in_div_zero;
      ovf_d      = in_ovf;
`ifdef DIV_FAST_SPECIAL_EN
      if (in_div_zero | in_ovf) begin
        state_d = DIV_STATE_DONE;
        val_d   = special_val;
      end
`endif
    end

    // A flush also suppresses the result write of a step finishing this cycle
    if (kill) begin
      state_d = DIV_STATE_IDLE;
      val_d   = val_q;
    end

    busy_d  = (state_d == DIV_STATE_CALC);
    valid_d = (state_d == DIV_STATE_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= DIV_STATE_IDLE;
      op_q       <= '0;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      divisor_q  <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      val_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      divisor_q  <= divisor_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      val_q      <= val_d;
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign val   = val_q;

endmodule

// File: doc/div_unit.md
# div_unit

Iterative multi-cycle integer divider for the FMRT Mini Core execute stage. It sits beside the single-cycle `alu` and handles the RISC-V M-extension divide and remainder operations DIV, DIVU, REM and REMU. Each operation uses one restoring-division step per clock, with a start/busy/valid handshake and a flush input. The execute stage stalls on `busy` and takes the result when `valid` is high.

## Interface
- `WORD_W`, default `` `WORD_DATA_W `` (32): operand and result width.
- `clk`  in  1: clock.
- `reset`  in  1: reset. Synchronous, active-high; one clock; no other clock domains.
- `start`  in  1: request. Sampled only when the unit can accept (see Operation).
- `op`  in  2: `` `DIV_OP_DIV `` = 0, `` `DIV_OP_DIVU `` = 1, `` `DIV_OP_REM `` = 2, `` `DIV_OP_REMU `` = 3.
- `arg0`  in  WORD_W: dividend. Two's complement for DIV/REM.
- `arg1`  in  WORD_W: divisor.
- `kill`  in  1: pipeline flush. Aborts any operation.
- `busy`  out  1: high while iterating.
- `valid`  out  1: result strobe. High for exactly one cycle.
- `val`  out  WORD_W: result. Held stable until the next accepted start.

## Operation
- States:
  - IDLE: ready for a new request.
  - CALC: iterating.
  - DONE: result valid.
- Accepting a request:
  - `start` is accepted in IDLE or DONE.
  - `start` is ignored in CALC.
  - On acceptance, latch `op`, |arg0|, |arg1|, and the sign flags (signed ops only). Clear the 6-bit step counter and the 33-bit partial remainder.
- CALC step:
  - Shift the remainder left by one and bring in the next dividend MSB.
  - Trial-subtract the divisor.
  - If the trial result is non-negative, keep it and shift a 1 into the quotient; otherwise shift in a 0.
  - After step 32, go to DONE.
- Sign fix-up (on entry to DONE):
  - Quotient is negated if the signs differ (DIV).
  - Remainder takes the dividend's sign (REM).
- Special cases (results required regardless of configuration):
  - Divisor 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → arg0.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- DONE: `valid` = 1. Next state is CALC if `start` is high, otherwise IDLE.
- `kill`:
  - Forces IDLE on the next edge from any state.
  - No `valid` is produced. `val` is unchanged.
  - `kill` and `start` in the same cycle: `kill` wins and the request is dropped.
- `reset`: state IDLE, `busy` 0, `valid` 0, `val` 0, counter 0. Reset applied mid-operation discards the operation.

## Timing
- Cycle T is the cycle in which `start` is accepted. On the normal path:
  - `busy` = 1 in cycles T+1 … T+32.
  - `valid` = 1 in cycle T+33.
  - Latency is 33 cycles.
- `busy` is 0 in IDLE and DONE.
- `valid` is never high at the same time as `busy`.
- Back-to-back: if `start` is high in the DONE cycle, the new operation enters CALC on the next edge. Throughput is one result per 33 cycles.
- `val` updates on the edge that enters DONE.

## Configuration
- Macro: `DIV_FAST_SPECIAL_EN`.
- Defined:
  - Divisor-zero and signed-overflow requests skip CALC and go IDLE/DONE → DONE.
  - `valid` is high in T+1 with the special-case result; `busy` is never asserted.
- Undefined:
  - Special cases run the full 32 steps; `valid` is high in T+33.
  - Special-case results are substituted at the DONE fix-up. Values are identical to the defined case.

## Structure
- Shared package / defines header (`base_core_defines.v`):
  - `` `DIV_OP_BUS `` and the four `` `DIV_OP_* `` encodings.
  - State encodings `` `DIV_STATE_IDLE/CALC/DONE ``.
  - `` `DIV_STEPS `` = 32.
- Sub-module `div_step`: combinational single restoring step.
  - Inputs: partial remainder (33 b), divisor (32 b), dividend MSB.
  - Outputs: next remainder, quotient bit.
  - Instantiated once in `div_unit`.

## Test plan
- DIV 100 / 7, start at T → `busy` high in T+1…T+32; `valid` in T+33; `val` = 14. Then REM on the same operands → 2.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD (−3). REM → 0xFFFFFFFF (−1). DIVU 0xFFFFFFFF / 2 → 0x7FFFFFFF.
- DIV 5 / 0 → 0xFFFFFFFF. REM 5 / 0 → 5. `valid` in T+1 with `DIV_FAST_SPECIAL_EN`, in T+33 without it.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM → 0.
- DIVU 9 / 3 started at T; `kill` in T+10 → `busy` 0 from T+11, no `valid` pulse, `val` unchanged. `start` in T+11 with DIVU 8 / 2 → `val` 4 in T+44.
- `start` held high through the DONE cycle → second operation's `valid` 33 cycles after the first. `reset` asserted in T+5 → all outputs 0 on the next cycle.
